instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Upstream neighbour of the immediate/decode stage. Holds the program counter, fetches one 32-bit
//  instruction per request from instruction memory over a req/ack handshake with variable latency,
//  and presents a registered instruction plus opcode field to decode. Supports downstream stall and
//  branch/jump redirect, including squash of an in-flight fetch.
// PARAMETERS
//  RESET_PC   32'h0040_0000  PC loaded on reset (text base)
//  NOP_INSTR  32'h0000_0013  instruction_o value while no valid fetch is held (addi x0,x0,0)
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  reset          in   1   synchronous, active-high reset
//  mem_req_o      out  1   fetch request to instruction memory
//  mem_addr_o     out  32  fetch address, word aligned
//  mem_ack_i      in   1   memory response strobe, one cycle; mem_rdata_i valid in same cycle
//  mem_rdata_i    in   32  fetched instruction word
//  stall_i        in   1   decode cannot accept the held instruction this cycle
//  redirect_i     in   1   branch/jump taken; load redirect_pc_i
//  redirect_pc_i  in   32  redirect target; bits [1:0] forced to 0 internally
//  instruction_o  out  32  held instruction (registered)
//  op_o           out  7   instruction_o[6:0], feeds decode/immediate opcode input
//  pc_o           out  32  address of instruction_o
//  pc_plus4_o     out  32  pc_o + 4, mod 2^32 (combinational from PC register)
//  valid_o        out  1   instruction_o/pc_o hold a live fetched instruction
// BEHAVIOUR
//  Reset (while reset=1, and on the edge it is sampled): state=IDLE, pc=RESET_PC, pending_pc=RESET_PC,
//   instruction=NOP_INSTR, valid_o=0, mem_req_o=0. Reset overrides every other input, mid-fetch included.
//  Memory protocol: mem_req_o and mem_addr_o held stable from assertion until the cycle mem_ack_i=1
//   (inclusive). mem_ack_i while mem_req_o=0 is ignored (covers late acks after reset).
//  States:
//   IDLE   : req=0, valid=0. Next cycle -> REQ.
//   REQ    : req=1, addr=pc. ack&!redirect -> latch rdata, valid=1 next cycle, -> HOLD.
//            redirect&ack -> drop rdata, pc<=redirect_pc, stay REQ (new addr next cycle).
//            redirect&!ack -> pending_pc<=redirect_pc, -> SQUASH.  neither -> stay.
//   HOLD   : req=0, valid=1. redirect (priority over stall) -> pc<=redirect_pc, valid=0, -> REQ.
//            !stall -> instruction consumed this cycle; pc<=pc+4, valid=0, -> REQ.  stall -> hold all.
//   SQUASH : req=1, addr=old pc (unchanged), valid=0. Further redirect overwrites pending_pc (last wins).
//            ack -> discard rdata, pc<=pending_pc (or redirect_pc if redirect same cycle), -> REQ.
//  Latency: req rising to valid_o = memory ack latency + 1 cycle. Zero-wait memory: one instruction
//   per 2 cycles (REQ,HOLD). instruction_o changes only on REQ->HOLD load; otherwise holds last value.
//  op_o always equals instruction_o[6:0]; pc_o equals pc register; stable while stall_i=1.
//  Arithmetic: pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000. No misalign trap; redirect bits[1:0] cleared.
//  Illegal state encoding recovers to IDLE.
// STRUCTURE
//  Shared header fetch_defs.vh: state encodings (IDLE/REQ/HOLD/SQUASH, 2 bits), NOP_INSTR constant,
//   default RESET_PC.
//  One sub-module: pc_register (32-bit register, sync reset to RESET_PC, load enable, D input);
//   next-PC mux and FSM live in this module.
// TESTING
//  1 reset, zero-wait memory, stall_i=0 -> addrs 0x00400000,0x00400004,0x00400008; valid_o every 2nd cycle,
//    op_o = rdata[6:0] (e.g. rdata 0x00500093 -> op_o 0x13).
//  2 3-cycle ack latency -> mem_req_o/mem_addr_o stable 3 cycles; valid_o 1 cycle after ack.
//  3 stall_i=1 for 5 cycles in HOLD -> instruction_o/pc_o/valid_o unchanged, no request; release -> pc+4.
//  4 redirect to 0x00400103 during outstanding 4-cycle fetch -> old data discarded (valid_o never 1),
//    next request addr 0x00400100; second redirect before ack to 0x00400200 -> 0x00400200 wins.
//  5 redirect and stall same cycle in HOLD -> redirect wins; pc=0xFFFFFFFC consumed -> next addr 0x0.
//  6 reset asserted mid-fetch, ack arrives after reset released -> ack ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encodings,
// default reset PC, the NOP instruction and the PC alignment helper.
package instruction_fetch_unit_pkg;

    // FSM state encodings (2 bits, every code is a legal state)
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_SQUASH = 2'd3;

    // Text base loaded into the PC on reset
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0040_0000;
    // addi x0,x0,0 : shown on instruction_o until the first fetch lands
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
    // Clears the two byte-offset bits of a fetch address
    localparam logic [31:0] PC_ALIGN_MASK     = 32'hFFFF_FFFC;

    // Word-align an address (no misalign trap, low bits are simply dropped)
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// 32-bit program-counter style register with synchronous active-high reset
// to a parameterised value and a load enable. Used for both the live PC and
// the pending redirect target of a squashed fetch.
module instruction_fetch_unit_pc_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VALUE = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [31:0] i_d,
    output logic [31:0] o_q
);

    logic [31:0] r_q;

    // Register update: reset wins over load, otherwise hold
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples pre-edge values regardless of block evaluation order.
        if (reset) begin
            r_q <= RESET_VALUE;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one 32-bit word per request
// over a variable-latency req/ack handshake, and presents a registered
// instruction to decode. Handles downstream stall and branch/jump redirect,
// including squash of a fetch that is already in flight.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instruction_o,
    output logic [6:0]  op_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    logic [1:0]  r_state;
    logic [31:0] r_instruction;

    logic [1:0]  w_state_next;
    logic        w_pc_load;
    logic [31:0] w_pc_d;
    logic        w_pend_load;
    logic        w_instr_load;
    logic [31:0] w_pc;
    logic [31:0] w_pending_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc;

    assign w_redirect_pc = align_pc(redirect_pc_i);
    assign w_pc_plus4    = w_pc + 32'd4;

    // Live PC: address of the held / in-flight instruction
    instruction_fetch_unit_pc_register #(
        .RESET_VALUE (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_pc_load),
        .i_d    (w_pc_d),
        .o_q    (w_pc)
    );

    // Redirect target remembered while a doomed fetch drains
    instruction_fetch_unit_pc_register #(
        .RESET_VALUE (RESET_PC)
    ) u_pending_pc_reg (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_pend_load),
        .i_d    (w_redirect_pc),
        .o_q    (w_pending_pc)
    );

    // Next-state, next-PC and load-enable decode
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        w_state_next = r_state;
        w_pc_load    = 1'b0;
        w_pc_d       = w_pc;
        w_pend_load  = 1'b0;
        w_instr_load = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_REQ;
            end
            ST_REQ: begin
                if (mem_ack_i && redirect_i) begin
                    // Data arrived for a now-wrong path: drop it, refetch at target
                    w_pc_load = 1'b1;
                    w_pc_d    = w_redirect_pc;
                end else if (mem_ack_i) begin
                    w_instr_load = 1'b1;
                    w_state_next = ST_HOLD;
                end else if (redirect_i) begin
                    // Request must stay stable until acked, so park the target
                    w_pend_load  = 1'b1;
                    w_state_next = ST_SQUASH;
                end
            end
            ST_HOLD: begin
                if (redirect_i) begin
                    w_pc_load    = 1'b1;
                    w_pc_d       = w_redirect_pc;
                    w_state_next = ST_REQ;
                end else if (!stall_i) begin
                    w_pc_load    = 1'b1;
                    w_pc_d       = w_pc_plus4;
                    w_state_next = ST_REQ;
                end
            end
            ST_SQUASH: begin
                // Latest redirect wins, including one in the ack cycle
                w_pend_load = redirect_i;
                if (mem_ack_i) begin
                    w_pc_load    = 1'b1;
                    w_pc_d       = redirect_i ? w_redirect_pc : w_pending_pc;
                    w_state_next = ST_REQ;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state and held instruction registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_instruction <= NOP_INSTR;
        end else begin
            r_state <= w_state_next;
            if (w_instr_load) begin
                r_instruction <= mem_rdata_i;
            end
        end
    end

    assign mem_req_o     = (r_state == ST_REQ) || (r_state == ST_SQUASH);
    assign mem_addr_o    = w_pc;
    assign valid_o       = (r_state == ST_HOLD);
    assign instruction_o = r_instruction;
    assign op_o          = r_instruction[6:0];
    assign pc_o          = w_pc;
    assign pc_plus4_o    = w_pc_plus4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a table of per-cycle
// vectors, hand-written multi-cycle sequences, and a randomized run against
// a transaction-level reference model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'd0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic [31:0] instruction_o;
    logic [6:0]  op_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;

    int n_checks = 0;
    int n_errors = 0;

    instruction_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instruction_o (instruction_o),
        .op_o          (op_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .valid_o       (valid_o)
    );

    always #5 clk = ~clk;

    // One cycle of table stimulus plus the outputs expected during that cycle
    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    // Reference model: a fetch is either idle-after-reset, outstanding, or
    // held. Any redirect while a fetch is outstanding kills it; when it
    // completes the PC becomes the most recent redirect target.
    logic        m_boot, m_busy, m_kill, m_have;
    logic [31:0] m_pc, m_target, m_instr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic e_valid, input logic [31:0] e_instr, input logic [31:0] e_pc);
        logic [31:0] e_pc4;
        e_pc4 = e_pc + 32'd4;
        check({tag, ".req"}, {31'd0, mem_req_o}, {31'd0, e_req});
        if (e_req) check({tag, ".addr"}, mem_addr_o, e_addr);
        check({tag, ".valid"}, {31'd0, valid_o}, {31'd0, e_valid});
        check({tag, ".instr"}, instruction_o, e_instr);
        check({tag, ".op"}, {25'd0, op_o}, {25'd0, e_instr[6:0]});
        check({tag, ".pc"}, pc_o, e_pc);
        check({tag, ".pc4"}, pc_plus4_o, e_pc4);
    endtask

    // Drive one cycle of inputs from a falling edge and advance to the next one
    task automatic cyc(input logic ack, input logic [31:0] rd, input logic st,
                       input logic rdir, input logic [31:0] rpc);
        mem_ack_i     = ack;
        mem_rdata_i   = rd;
        stall_i       = st;
        redirect_i    = rdir;
        redirect_pc_i = rpc;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ack_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_out("reset", 1'b0, RPC, 1'b0, NOP, RPC);
        reset = 1'b0;
    endtask

    task automatic add_vec(input logic ack, input logic [31:0] rd, input logic st, input logic rdir,
                           input logic [31:0] rpc, input logic e_req, input logic [31:0] e_addr,
                           input logic e_valid, input logic [31:0] e_instr, input logic [31:0] e_pc);
        vec_t v;
        v.ack = ack; v.rdata = rd; v.stall = st; v.redir = rdir; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc = e_pc;
        vecs.push_back(v);
    endtask

    task automatic model_reset();
        m_boot = 1'b1; m_busy = 1'b0; m_kill = 1'b0; m_have = 1'b0;
        m_pc = RPC; m_target = RPC; m_instr = NOP;
    endtask

    task automatic model_step(input logic rst, input logic ack, input logic [31:0] rd,
                              input logic st, input logic rdir, input logic [31:0] rpc);
        logic [31:0] tgt;
        tgt = {rpc[31:2], 2'b00};
        if (rst) begin
            model_reset();
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_busy = 1'b1;
        end else if (m_have) begin
            if (rdir || !st) begin
                m_pc   = rdir ? tgt : m_pc + 32'd4;
                m_have = 1'b0;
                m_busy = 1'b1;
            end
        end else if (m_busy) begin
            if (rdir) begin
                m_kill   = 1'b1;
                m_target = tgt;
            end
            if (ack && m_kill) begin
                m_pc   = m_target;
                m_kill = 1'b0;
            end else if (ack) begin
                m_instr = rd;
                m_have  = 1'b1;
                m_busy  = 1'b0;
            end
        end
    endtask

    initial begin
        // ---------------- Table: zero-wait fetches, stall, redirect+stall, wrap
        add_vec(0, 32'h0,          0, 0, 32'h0,          0, RPC,           0, NOP,           RPC);
        add_vec(1, 32'h0050_0093,  0, 0, 32'h0,          1, RPC,           0, NOP,           RPC);
        add_vec(0, 32'h0,          0, 0, 32'h0,          0, RPC,           1, 32'h0050_0093, RPC);
        add_vec(1, 32'h0040_006F,  0, 0, 32'h0,          1, RPC + 4,       0, 32'h0050_0093, RPC + 4);
        add_vec(0, 32'h0,          0, 0, 32'h0,          0, RPC + 4,       1, 32'h0040_006F, RPC + 4);
        add_vec(1, 32'h0000_0537,  0, 0, 32'h0,          1, RPC + 8,       0, 32'h0040_006F, RPC + 8);
        for (int i = 0; i < 5; i++)
            add_vec(i == 2, 32'hBAD0_BAD0, 1, 0, 32'h0,  0, RPC + 8,       1, 32'h0000_0537, RPC + 8);
        add_vec(0, 32'h0,          0, 0, 32'h0,          0, RPC + 8,       1, 32'h0000_0537, RPC + 8);
        add_vec(1, 32'h0010_8093,  0, 0, 32'h0,          1, RPC + 12,      0, 32'h0000_0537, RPC + 12);
        add_vec(0, 32'h0,          1, 1, 32'hFFFF_FFFF,  0, RPC + 12,      1, 32'h0010_8093, RPC + 12);
        add_vec(1, 32'h0000_00B3,  0, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h0010_8093, 32'hFFFF_FFFC);
        add_vec(0, 32'h0,          0, 0, 32'h0,          0, 32'hFFFF_FFFC, 1, 32'h0000_00B3, 32'hFFFF_FFFC);
        add_vec(0, 32'h0,          0, 0, 32'h0,          1, 32'h0,         0, 32'h0000_00B3, 32'h0);
        add_vec(0, 32'h0,          0, 0, 32'h0,          1, 32'h0,         0, 32'h0000_00B3, 32'h0);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            check_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                      vecs[i].e_instr, vecs[i].e_pc);
            cyc(vecs[i].ack, vecs[i].rdata, vecs[i].stall, vecs[i].redir, vecs[i].rpc);
        end

        // ---------------- 3-cycle ack latency: request stable, valid one cycle after ack
        do_reset();
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check_out($sformatf("lat%0d", i), 1'b1, RPC, 1'b0, NOP, RPC);
            cyc(i == 2, 32'h0020_0113, 0, 0, 0);
        end
        check_out("lat_done", 1'b0, RPC, 1'b1, 32'h0020_0113, RPC);

        // ---------------- Redirect during outstanding fetch, then last-wins redirect
        do_reset();
        cyc(0, 0, 0, 0, 0);
        check_out("sq_a0", 1'b1, RPC, 1'b0, NOP, RPC);
        cyc(0, 0, 0, 0, 0);
        check_out("sq_a1", 1'b1, RPC, 1'b0, NOP, RPC);
        cyc(0, 0, 0, 1, 32'h0040_0103);
        check_out("sq_a2", 1'b1, RPC, 1'b0, NOP, RPC);
        cyc(0, 0, 0, 0, 0);
        check_out("sq_a3", 1'b1, RPC, 1'b0, NOP, RPC);
        cyc(1, 32'hDEAD_BEEF, 0, 0, 0);
        check_out("sq_a4", 1'b1, 32'h0040_0100, 1'b0, NOP, 32'h0040_0100);
        cyc(0, 0, 0, 1, 32'h0040_0300);
        check_out("sq_b0", 1'b1, 32'h0040_0100, 1'b0, NOP, 32'h0040_0100);
        cyc(0, 0, 0, 1, 32'h0040_0200);
        check_out("sq_b1", 1'b1, 32'h0040_0100, 1'b0, NOP, 32'h0040_0100);
        cyc(0, 0, 0, 0, 0);
        check_out("sq_b2", 1'b1, 32'h0040_0100, 1'b0, NOP, 32'h0040_0100);
        cyc(1, 32'hCAFE_F00D, 0, 0, 0);
        check_out("sq_b3", 1'b1, 32'h0040_0200, 1'b0, NOP, 32'h0040_0200);
        cyc(1, 32'h0000_2083, 0, 0, 0);
        check_out("sq_b4", 1'b0, 32'h0040_0200, 1'b1, 32'h0000_2083, 32'h0040_0200);

        // ---------------- Reset mid-fetch, late ack after release is ignored
        do_reset();
        cyc(0, 0, 0, 0, 0);
        cyc(1, 32'h00A0_0093, 0, 0, 0);
        check_out("rst_hold", 1'b0, RPC, 1'b1, 32'h00A0_0093, RPC);
        cyc(0, 0, 0, 0, 0);
        check_out("rst_req", 1'b1, RPC + 4, 1'b0, 32'h00A0_0093, RPC + 4);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0);
        check_out("rst_mid", 1'b0, RPC, 1'b0, NOP, RPC);
        reset = 1'b0;
        cyc(1, 32'h1111_1111, 0, 0, 0);
        check_out("rst_late0", 1'b1, RPC, 1'b0, NOP, RPC);
        cyc(0, 0, 0, 0, 0);
        check_out("rst_late1", 1'b1, RPC, 1'b0, NOP, RPC);
        cyc(1, 32'h0000_0093, 0, 0, 0);
        check_out("rst_late2", 1'b0, RPC, 1'b1, 32'h0000_0093, RPC);

        // ---------------- Randomized run against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic        r_rst, r_ack, r_st, r_rdir;
            logic [31:0] r_data, r_tgt;
            check_out($sformatf("rnd%0d", c), m_busy, m_pc, m_have, m_instr, m_pc);
            r_rst  = ($urandom_range(63) == 0);
            r_st   = 1'($urandom_range(1));
            r_rdir = ($urandom_range(5) == 0);
            r_tgt  = $urandom;
            r_data = $urandom;
            r_ack  = m_busy ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
            reset  = r_rst;
            model_step(r_rst, r_ack, r_data, r_st, r_rdir, r_tgt);
            cyc(r_ack, r_data, r_st, r_rdir, r_tgt);
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
